// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the round-timer controller: state codes,
// seven-segment glyphs and digit-select encodings.
package timer_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RUNNING = 3'd2;
    localparam logic [2:0] ST_PAUSED  = 3'd3;
    localparam logic [2:0] ST_EXPIRED = 3'd4;

    // Segment order is {dp,g,f,e,d,c,b,a}, active-high
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;

    localparam logic [1:0] DIG_UNITS = 2'b01;
    localparam logic [1:0] DIG_TENS  = 2'b10;

    function automatic logic [7:0] seg_glyph(input logic [3:0] digit);
        logic [7:0] glyph;
        case (digit)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/timer_ctrl_seg7_scan.sv
// Two-digit multiplexed seven-segment driver: scan divider, digit mux
// and glyph decode, with registered anode and segment outputs.
module seg7_scan
    import timer_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       blank_tens,
    input  logic       blank_all,
    output logic [1:0] o_an,
    output logic [7:0] o_seg
);

    localparam int SCAN_DIV = CLK_FREQ / (2 * SCAN_HZ);
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick;

    assign tick = (scan_cnt_q == SW'(SCAN_DIV - 1));

    // Segments follow the digit that will be enabled next cycle so that
    // anode and segment pattern always change on the same edge.
    always_comb begin
        scan_cnt_d = tick ? '0 : scan_cnt_q + SW'(1);
        an_d       = an_q;
        if (tick) begin
            an_d = (an_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
        end
        seg_d = seg_glyph(units);
        if (blank_all) begin
            seg_d = SEG_BLANK;
        end else if (an_d == DIG_TENS) begin
            seg_d = blank_tens ? SEG_BLANK : seg_glyph(tens);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            an_q       <= DIG_UNITS;
            seg_q      <= SEG_BLANK;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign o_an  = an_q;
    assign o_seg = seg_q;

endmodule

// File: rtl/timer_ctrl.sv
// Round-timer controller: sequences the countdown timer, reports expiry
// and shows the remaining seconds on two multiplexed digits.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_arm,
    input  logic       i_pause,
    input  logic       i_abort,
    input  logic       i_ack,
    input  logic [3:0] i_sec_cfg,
    input  logic       i_timeout,
    input  logic [3:0] i_time_val,
    output logic       o_start_timer,
    output logic       o_en,
    output logic [3:0] o_load_sec,
    output logic       o_expired,
    output logic       o_busy,
    output logic [2:0] o_state,
    output logic [1:0] o_an,
    output logic [7:0] o_seg
);

    localparam int BLINK_HALF = CLK_FREQ / (2 * BLINK_HZ);
    localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [2:0]    state_q, state_d;
    logic [3:0]    load_sec_q, load_sec_d;
    logic          expired_q, expired_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;
    logic          arm_accept;
    logic [3:0]    disp_val;
    logic [3:0]    tens, units;
    logic          blank_tens, blank_all;

    // A zero-length round can never time out, so it expires on the spot.
    always_comb begin
        state_d    = state_q;
        load_sec_d = load_sec_q;
        expired_d  = 1'b0;
        arm_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arm_accept = i_arm;
            end
            ST_LOAD: begin
                state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (i_timeout) begin
                    state_d   = ST_EXPIRED;
                    expired_d = 1'b1;
                end else if (i_arm) begin
                    arm_accept = 1'b1;
                end else if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (i_pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (i_arm) begin
                    arm_accept = 1'b1;
                end else if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (!i_pause) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_EXPIRED: begin
                if (i_arm) begin
                    arm_accept = 1'b1;
                end else if (i_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (arm_accept) begin
            if (i_sec_cfg == 4'd0) begin
                state_d   = ST_EXPIRED;
                expired_d = 1'b1;
            end else begin
                state_d    = ST_LOAD;
                load_sec_d = i_sec_cfg;
            end
        end
    end

    // Blink divider only runs while paused; it restarts in the "on" phase.
    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (state_q == ST_PAUSED) begin
            if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_off_d = blink_off_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            load_sec_q  <= 4'd10;
            expired_q   <= 1'b0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_sec_q  <= load_sec_d;
            expired_q   <= expired_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    always_comb begin
        disp_val = 4'd0;
        case (state_q)
            ST_IDLE:                          disp_val = i_sec_cfg;
            ST_LOAD, ST_RUNNING, ST_PAUSED:   disp_val = i_time_val;
            default:                          disp_val = 4'd0;
        endcase
    end

    assign blank_tens = (disp_val < 4'd10);
    assign tens       = blank_tens ? 4'd0 : 4'd1;
    assign units      = blank_tens ? disp_val : disp_val - 4'd10;
    assign blank_all  = (state_q == ST_PAUSED) && blink_off_q;

    seg7_scan #(
        .CLK_FREQ(CLK_FREQ),
        .SCAN_HZ (SCAN_HZ)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .tens      (tens),
        .units     (units),
        .blank_tens(blank_tens),
        .blank_all (blank_all),
        .o_an      (o_an),
        .o_seg     (o_seg)
    );

    assign o_start_timer = (state_q == ST_LOAD);
    assign o_en          = (state_q == ST_RUNNING);
    assign o_busy        = (state_q == ST_LOAD) || (state_q == ST_RUNNING) || (state_q == ST_PAUSED);
    assign o_state       = state_q;
    assign o_load_sec    = load_sec_q;
    assign o_expired     = expired_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: a vector table through a scoreboard
// for the FSM, then hand sequences with a countdown timer model.
module tb_timer_ctrl;

    localparam int CLK_FREQ = 100;
    localparam int SCAN_HZ  = 10;
    localparam int BLINK_HZ = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0, pause = 1'b0, abort = 1'b0, ack = 1'b0;
    logic [3:0] sec_cfg = 4'd0;
    logic       man_timeout = 1'b0;
    logic [3:0] man_time_val = 4'd0;
    logic       model_on = 1'b0;
    logic       timeout;
    logic [3:0] time_val;
    logic       start_timer, en, expired, busy;
    logic [3:0] load_sec;
    logic [2:0] state;
    logic [1:0] an;
    logic [7:0] seg;

    // Countdown timer model driven by the controller's start/enable
    logic [3:0] tm_val;
    int         tm_cnt;
    logic       tm_to;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       arm, pause, abort, ack, timeout;
        logic [3:0] cfg;
        logic [2:0] e_state;
        logic       e_start, e_en, e_exp, e_busy;
        logic [3:0] e_load;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] e_state;
        logic       e_start, e_en, e_exp, e_busy;
        logic [3:0] e_load;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    assign timeout  = model_on ? tm_to  : man_timeout;
    assign time_val = model_on ? tm_val : man_time_val;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_val <= 4'd0;
            tm_cnt <= 0;
            tm_to  <= 1'b0;
        end else begin
            tm_to <= 1'b0;
            if (start_timer) begin
                tm_val <= load_sec;
                tm_cnt <= 0;
            end else if (en && tm_val != 4'd0) begin
                if (tm_cnt == CLK_FREQ - 1) begin
                    tm_cnt <= 0;
                    tm_val <= tm_val - 4'd1;
                    if (tm_val == 4'd1) tm_to <= 1'b1;
                end else begin
                    tm_cnt <= tm_cnt + 1;
                end
            end
        end
    end

    timer_ctrl #(
        .CLK_FREQ(CLK_FREQ),
        .SCAN_HZ (SCAN_HZ),
        .BLINK_HZ(BLINK_HZ)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_arm        (arm),
        .i_pause      (pause),
        .i_abort      (abort),
        .i_ack        (ack),
        .i_sec_cfg    (sec_cfg),
        .i_timeout    (timeout),
        .i_time_val   (time_val),
        .o_start_timer(start_timer),
        .o_en         (en),
        .o_load_sec   (load_sec),
        .o_expired    (expired),
        .o_busy       (busy),
        .o_state      (state),
        .o_an         (an),
        .o_seg        (seg)
    );

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic p, input logic ab, input logic ak,
                         input logic [3:0] cfg, input logic to);
        arm = a; pause = p; abort = ab; ack = ak; sec_cfg = cfg; man_timeout = to;
    endtask

    function automatic vec_t mk(input logic a, input logic p, input logic ab, input logic ak,
                                input logic to, input logic [3:0] cfg, input logic [2:0] st,
                                input logic s, input logic e, input logic x, input logic b,
                                input logic [3:0] ld);
        vec_t v;
        v.arm = a; v.pause = p; v.abort = ab; v.ack = ak; v.timeout = to; v.cfg = cfg;
        v.e_state = st; v.e_start = s; v.e_en = e; v.e_exp = x; v.e_busy = b; v.e_load = ld;
        return v;
    endfunction

    task automatic applyStimulus(input int idx, input vec_t v);
        exp_t e;
        drive(v.arm, v.pause, v.abort, v.ack, v.cfg, v.timeout);
        e.idx = idx; e.e_state = v.e_state; e.e_start = v.e_start; e.e_en = v.e_en;
        e.e_exp = v.e_exp; e.e_busy = v.e_busy; e.e_load = v.e_load;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checkValue("scoreboard empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        checkValue($sformatf("v%0d state", e.idx),   state,       e.e_state);
        checkValue($sformatf("v%0d start", e.idx),   start_timer, e.e_start);
        checkValue($sformatf("v%0d en", e.idx),      en,          e.e_en);
        checkValue($sformatf("v%0d expired", e.idx), expired,     e.e_exp);
        checkValue($sformatf("v%0d busy", e.idx),    busy,        e.e_busy);
        checkValue($sformatf("v%0d load", e.idx),    load_sec,    e.e_load);
    endtask

    task automatic checkReset(input string tag);
        checkValue({tag, " state"},   state,       3'd0);
        checkValue({tag, " load"},    load_sec,    4'd10);
        checkValue({tag, " start"},   start_timer, 1'b0);
        checkValue({tag, " en"},      en,          1'b0);
        checkValue({tag, " expired"}, expired,     1'b0);
        checkValue({tag, " busy"},    busy,        1'b0);
        checkValue({tag, " an"},      an,          2'b01);
        checkValue({tag, " seg"},     seg,         8'h00);
    endtask

    // Samples the display for n cycles; checks glyphs and the 5-cycle scan period
    task automatic checkDisplay(input string tag, input int n, input logic [7:0] g_units,
                                input logic [7:0] g_tens);
        logic [1:0] last_an;
        int         since;
        bit         seen_change;
        last_an = an; since = 0; seen_change = 0;
        for (int k = 0; k < n; k++) begin
            if (an == 2'b01)      checkValue({tag, " units seg"}, seg, g_units);
            else if (an == 2'b10) checkValue({tag, " tens seg"},  seg, g_tens);
            else                  checkValue({tag, " an onehot"}, an,  2'b01);
            step();
            since++;
            if (an != last_an) begin
                if (seen_change) checkValue({tag, " scan period"}, since, 5);
                seen_change = 1;
                since = 0;
                last_an = an;
            end
        end
    endtask

    initial begin
        int c;
        int starts;
        int bad_en, bad_off, on_seen, on_again;
        logic [3:0] frozen;
        bit done;

        // Reset state
        drive(0, 0, 0, 0, 4'd0, 0);
        #23;
        checkReset("reset");
        rst_n = 1'b1;
        step();
        checkValue("post-reset state", state, 3'd0);

        vecs.push_back(mk(1,0,0,0,0, 4'd3,  3'd1, 1,0,0,1, 4'd3));
        vecs.push_back(mk(0,0,0,0,0, 4'd3,  3'd2, 0,1,0,1, 4'd3));
        vecs.push_back(mk(0,1,0,0,0, 4'd3,  3'd3, 0,0,0,1, 4'd3));
        vecs.push_back(mk(0,1,0,0,1, 4'd3,  3'd3, 0,0,0,1, 4'd3));
        vecs.push_back(mk(0,0,0,0,0, 4'd3,  3'd2, 0,1,0,1, 4'd3));
        vecs.push_back(mk(0,0,1,0,1, 4'd3,  3'd4, 0,0,1,0, 4'd3));
        vecs.push_back(mk(0,0,0,0,0, 4'd3,  3'd4, 0,0,0,0, 4'd3));
        vecs.push_back(mk(1,0,0,1,0, 4'd7,  3'd1, 1,0,0,1, 4'd7));
        vecs.push_back(mk(0,0,0,0,0, 4'd7,  3'd2, 0,1,0,1, 4'd7));
        vecs.push_back(mk(1,0,1,0,0, 4'd9,  3'd1, 1,0,0,1, 4'd9));
        vecs.push_back(mk(0,0,0,0,0, 4'd9,  3'd2, 0,1,0,1, 4'd9));
        vecs.push_back(mk(0,1,1,0,0, 4'd9,  3'd0, 0,0,0,0, 4'd9));
        vecs.push_back(mk(1,0,0,0,0, 4'd0,  3'd4, 0,0,1,0, 4'd9));
        vecs.push_back(mk(0,0,0,1,0, 4'd0,  3'd0, 0,0,0,0, 4'd9));
        vecs.push_back(mk(1,0,0,0,0, 4'd15, 3'd1, 1,0,0,1, 4'd15));
        vecs.push_back(mk(0,0,0,0,0, 4'd15, 3'd2, 0,1,0,1, 4'd15));
        vecs.push_back(mk(1,0,0,0,0, 4'd0,  3'd4, 0,0,1,0, 4'd15));
        vecs.push_back(mk(1,0,0,0,0, 4'd0,  3'd4, 0,0,1,0, 4'd15));
        vecs.push_back(mk(1,0,0,1,0, 4'd2,  3'd1, 1,0,0,1, 4'd2));
        vecs.push_back(mk(0,0,0,0,0, 4'd2,  3'd2, 0,1,0,1, 4'd2));
        vecs.push_back(mk(0,1,0,0,0, 4'd2,  3'd3, 0,0,0,1, 4'd2));
        vecs.push_back(mk(1,1,0,0,0, 4'd6,  3'd1, 1,0,0,1, 4'd6));
        vecs.push_back(mk(0,1,0,0,0, 4'd6,  3'd2, 0,1,0,1, 4'd6));
        vecs.push_back(mk(0,1,0,0,0, 4'd6,  3'd3, 0,0,0,1, 4'd6));
        vecs.push_back(mk(0,1,1,0,0, 4'd6,  3'd0, 0,0,0,0, 4'd6));
        vecs.push_back(mk(0,0,0,1,0, 4'd6,  3'd0, 0,0,0,0, 4'd6));
        vecs.push_back(mk(0,0,0,0,1, 4'd6,  3'd0, 0,0,0,0, 4'd6));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i, vecs[i]);
            step();
            checkOutput();
        end
        drive(0, 0, 0, 0, 4'd0, 0);
        step();

        // Full round of 3 s with the timer model
        model_on = 1'b1;
        drive(1, 0, 0, 0, 4'd3, 0);
        starts = 0; done = 0; c = 0;
        while (!done && c < 1000) begin
            step();
            c++;
            if (c == 1) begin
                drive(0, 0, 0, 0, 4'd3, 0);
                checkValue("round start pulse", start_timer, 1'b1);
                checkValue("round load value", load_sec, 4'd3);
                checkValue("round en during load", en, 1'b0);
            end
            if (c == 2) checkValue("round en after load", en, 1'b1);
            if (start_timer) starts++;
            if (expired) done = 1;
        end
        checkValue("round expired seen", done, 1'b1);
        checkValue("round expiry near 300", (c >= 295 && c <= 310), 1'b1);
        checkValue("round single start", starts, 1);
        checkValue("round state expired", state, 3'd4);
        step();
        checkValue("round expired one cycle", expired, 1'b0);
        drive(0, 0, 0, 1, 4'd0, 0);
        step();
        drive(0, 0, 0, 0, 4'd0, 0);
        checkValue("round ack idle", state, 3'd0);

        // 5 s round with a 150-cycle pause
        drive(1, 0, 0, 0, 4'd5, 0);
        step();
        drive(0, 0, 0, 0, 4'd5, 0);
        c = 1;
        for (int k = 0; k < 199; k++) begin step(); c++; end
        pause = 1'b1;
        bad_en = 0; bad_off = 0; on_seen = 0; on_again = 0; frozen = 4'd0;
        for (int k = 1; k <= 150; k++) begin
            step();
            c++;
            if (k == 1) frozen = time_val;
            if (en) bad_en++;
            if (k >= 30 && k <= 45 && seg != 8'h00) bad_off++;
            if (k >= 1 && k <= 20 && seg != 8'h00) on_seen = 1;
            if (k >= 55 && k <= 70 && seg != 8'h00) on_again = 1;
        end
        checkValue("pause en low", bad_en, 0);
        checkValue("pause time frozen", time_val, frozen);
        checkValue("pause state", state, 3'd3);
        checkValue("blink off blank", bad_off, 0);
        checkValue("blink on visible", on_seen, 1);
        checkValue("blink on again", on_again, 1);
        pause = 1'b0;
        done = 0;
        while (!done && c < 2000) begin
            step();
            c++;
            if (expired) done = 1;
        end
        checkValue("paused round expired", done, 1'b1);
        checkValue("paused round delay", (c >= 645 && c <= 662), 1'b1);
        drive(0, 0, 0, 1, 4'd0, 0);
        step();
        drive(0, 0, 0, 0, 4'd0, 0);

        // Zero-length round never starts the timer
        drive(1, 0, 0, 0, 4'd0, 0);
        step();
        drive(0, 0, 0, 0, 4'd0, 0);
        checkValue("zero arm state", state, 3'd4);
        checkValue("zero arm expired", expired, 1'b1);
        starts = 0;
        for (int k = 0; k < 5; k++) begin
            if (start_timer) starts++;
            step();
        end
        checkValue("zero arm no start", starts, 0);
        drive(0, 0, 0, 1, 4'd0, 0);
        step();
        drive(0, 0, 0, 0, 4'd0, 0);

        // Display rendering
        model_on = 1'b0;
        man_time_val = 4'd12;
        drive(1, 0, 0, 0, 4'd12, 0);
        step();
        drive(0, 0, 0, 0, 4'd12, 0);
        step();
        checkDisplay("val12", 30, 8'h5B, 8'h06);
        man_time_val = 4'd7;
        step();
        checkDisplay("val7", 20, 8'h07, 8'h00);
        drive(0, 0, 1, 0, 4'd9, 0);
        step();
        drive(0, 0, 0, 0, 4'd9, 0);
        step();
        checkDisplay("idle9", 12, 8'h6F, 8'h00);
        drive(1, 0, 0, 0, 4'd0, 0);
        step();
        drive(0, 0, 0, 0, 4'd0, 0);
        step();
        checkDisplay("expired0", 12, 8'h3F, 8'h00);
        drive(0, 0, 0, 1, 4'd0, 0);
        step();
        drive(0, 0, 0, 0, 4'd0, 0);

        // Asynchronous reset while paused
        drive(1, 0, 0, 0, 4'd9, 0);
        step();
        drive(0, 1, 0, 0, 4'd9, 0);
        step();
        step();
        step();
        checkValue("pre-reset paused", state, 3'd3);
        #3;
        rst_n = 1'b0;
        #1;
        checkReset("async reset");
        drive(0, 0, 0, 0, 4'd0, 0);
        step();
        step();
        #2;
        rst_n = 1'b1;
        bad_en = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (expired) bad_en++;
        end
        checkValue("no expiry after reset", bad_en, 0);
        checkValue("idle after reset", state, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
